// File: rtl/ldst_pkg.sv
// ldst_pkg: shared entry state, entry struct and ID width helper for the load/store queue
package ldst_pkg;
  typedef enum logic [1:0] {FREE, PEND, ISSUED, DONE} ent_st_e;
  typedef struct packed {
    ent_st_e st;
    logic    rw;
  } ent_t;
  function automatic int id_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/ldst_fwd_match.sv
// ldst_fwd_match: age-ordered CAM returning the youngest older store matching an address
module ldst_fwd_match #(
  parameter int DEPTH  = 16,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic [ID_W-1:0]   head_i,
  input  logic [ID_W-1:0]   new_i,
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [DEPTH-1:0]  rw_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [ADDR_W-1:0] lookup_i,
  output logic              hit_o,
  output logic [ID_W-1:0]   idx_o
);
  logic [ID_W-1:0] span, j;
  // walk oldest to youngest so the last hit below new_i is the youngest older store
  always_comb begin
    span  = new_i - head_i;
    hit_o = 1'b0;
    idx_o = '0;
    j     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      j = head_i + ID_W'(k);
      if (ID_W'(k) < span && valid_i[j] && rw_i[j] && addr_i[j] == lookup_i) begin
        hit_o = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/ldst_queue_param.sv
// ldst_queue_param: in-order load/store queue with store-to-load forwarding and in-order retire
module ldst_queue_param
  import ldst_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ID_W    = id_width(DEPTH),
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNTRL_W = 4,
  parameter int Z_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memR,
  input  logic               memW,
  input  logic [ADDR_W-1:0]  addr_in_C,
  input  logic [DATA_W-1:0]  data_in_C,
  input  logic [CNTRL_W-1:0] cntrl_in_C,
  input  logic [Z_W-1:0]     Z_in_C,
  output logic [ADDR_W-1:0]  addr_out_C,
  output logic [DATA_W-1:0]  data_out_C,
  output logic [CNTRL_W-1:0] cntrl_out_C,
  output logic [Z_W-1:0]     Z_out_C,
  output logic               ready_out_C,
  output logic [ADDR_W-1:0]  addr_out_M,
  output logic [DATA_W-1:0]  data_out_M,
  output logic               rw_out_M,
  output logic [ID_W-1:0]    ldstID_out_M,
  output logic               valid_out_M,
  input  logic [DATA_W-1:0]  data_in_M,
  input  logic [ID_W-1:0]    ldstID_in_M,
  input  logic               ready_in_M,
  input  logic               stall_in_M,
  output logic               stall_out_C,
  output logic               empty,
  output logic               full,
  output logic [ID_W:0]      count
);
  ent_t               ent_q   [DEPTH];
  logic [ADDR_W-1:0]  addr_q  [DEPTH];
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [CNTRL_W-1:0] cntrl_q [DEPTH];
  logic [Z_W-1:0]     z_q     [DEPTH];
  logic [ID_W-1:0]    head_q, head_d, tail_q, tail_d, fwd_idx, iss_idx;
  logic [ID_W:0]      count_q, count_d;
  logic [DEPTH-1:0]   valid_v, rw_v;
  logic               alloc, fwd_ld, retire, rsp_ok, fwd_hit, iss_found, do_iss;

  assign full        = count_q == (ID_W+1)'(DEPTH);
  assign empty       = count_q == '0;
  assign count       = count_q;
  assign stall_out_C = full;
  assign alloc       = (memR | memW) & ~full;
  assign fwd_ld      = ~memW & fwd_hit;
  assign retire      = ent_q[head_q].st == DONE;
  assign rsp_ok      = ready_in_M && ent_q[ldstID_in_M].st == ISSUED;
  assign do_iss      = iss_found & ~stall_in_M;
  assign head_d      = head_q + ID_W'(retire);
  assign tail_d      = tail_q + ID_W'(alloc);
  assign count_d     = count_q + (ID_W+1)'(alloc) - (ID_W+1)'(retire);

  ldst_fwd_match #(.DEPTH(DEPTH), .ID_W(ID_W), .ADDR_W(ADDR_W)) u_fwd (
    .head_i  (head_q),
    .new_i   (tail_q),
    .valid_i (valid_v),
    .rw_i    (rw_v),
    .addr_i  (addr_q),
    .lookup_i(addr_in_C),
    .hit_o   (fwd_hit),
    .idx_o   (fwd_idx)
  );

  // flatten entry flags for the CAM and pick the oldest PEND entry counting from head
  always_comb begin
    valid_v   = '0;
    rw_v      = '0;
    iss_found = 1'b0;
    iss_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_v[i] = ent_q[i].st != FREE;
      rw_v[i]    = ent_q[i].rw;
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_q[head_q + ID_W'(k)].st == PEND) begin
        iss_found = 1'b1;
        iss_idx   = head_q + ID_W'(k);
      end
    end
  end

  // entry state machine, pointers and registered memory/core outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      valid_out_M  <= 1'b0;
      addr_out_M   <= '0;
      data_out_M   <= '0;
      rw_out_M     <= 1'b0;
      ldstID_out_M <= '0;
      ready_out_C  <= 1'b0;
      addr_out_C   <= '0;
      data_out_C   <= '0;
      cntrl_out_C  <= '0;
      Z_out_C      <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_out_M <= do_iss;
      ready_out_C <= retire;
      if (alloc) ent_q[tail_q] <= '{st: fwd_ld ? DONE : PEND, rw: memW};
      if (do_iss) begin
        ent_q[iss_idx].st <= ISSUED;
        addr_out_M        <= addr_q[iss_idx];
        data_out_M        <= data_q[iss_idx];
        rw_out_M          <= ent_q[iss_idx].rw;
        ldstID_out_M      <= iss_idx;
      end
      if (rsp_ok) ent_q[ldstID_in_M].st <= DONE;
      if (retire) begin
        ent_q[head_q].st <= FREE;
        addr_out_C       <= addr_q[head_q];
        data_out_C       <= data_q[head_q];
        cntrl_out_C      <= cntrl_q[head_q];
        Z_out_C          <= z_q[head_q];
      end
    end
  end

  // entry payload: written on allocation (with forwarded data) and on load responses
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q]  <= addr_in_C;
      data_q[tail_q]  <= fwd_ld ? data_q[fwd_idx] : data_in_C;
      cntrl_q[tail_q] <= cntrl_in_C;
      z_q[tail_q]     <= Z_in_C;
    end
    if (rsp_ok && !ent_q[ldstID_in_M].rw) data_q[ldstID_in_M] <= data_in_M;
  end
endmodule

// File: doc/ldst_queue_param.md
# ldst_queue_param

Parametrised in-order load/store queue between the core's memory stage and the data cache (`DCache4KBNew` interface).
- Accepts one load or store per cycle and tags it with a queue ID.
- Issues requests to memory in age order under memory backpressure.
- Forwards store data to younger loads of the same address without a memory access.
- Retires entries to the core strictly in program order.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, at least 2
- ID_W, 4, clog2(DEPTH); width of queue IDs and head/tail pointers
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNTRL_W, 4, opaque control tag carried with each entry
- Z_W, 4, destination-register tag carried with each entry

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- memR  in  1  allocate a load this cycle
- memW  in  1  allocate a store this cycle
- addr_in_C  in  ADDR_W  request address
- data_in_C  in  DATA_W  store data
- cntrl_in_C  in  CNTRL_W  control tag
- Z_in_C  in  Z_W  destination tag
- addr_out_C / data_out_C / cntrl_out_C / Z_out_C  out  ADDR_W/DATA_W/CNTRL_W/Z_W  retired entry fields
- ready_out_C  out  1  one-cycle pulse; a retired entry is on the _C outputs
- addr_out_M  out  ADDR_W  memory request address
- data_out_M  out  DATA_W  memory request data
- rw_out_M  out  1  1 = store, 0 = load
- ldstID_out_M  out  ID_W  request ID
- valid_out_M  out  1  request valid this cycle
- data_in_M  in  DATA_W  response data
- ldstID_in_M  in  ID_W  response ID
- ready_in_M  in  1  response valid
- stall_in_M  in  1  memory cannot accept a request
- stall_out_C  out  1  core must not allocate
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  ID_W+1  occupied entries

## Operation
- Each entry has a state: FREE, PEND (awaiting issue), ISSUED, DONE. Entries also hold rw, addr, data, cntrl, Z.
- Allocation:
  - memR or memW with !full writes the entry at tail and increments tail (mod DEPTH).
  - memR and memW together is treated as a store.
  - Allocation while full is dropped and the count is unchanged.
- Forwarding on load allocation:
  - Search the entries from head up to, but excluding, the new entry for the youngest non-FREE store with an identical full address.
  - On a hit: copy that store's data and mark the load DONE. The load is never sent to memory.
  - A matching older load never forwards.
  - A store is never blocked by an older load.
- Issue:
  - Each cycle, the oldest PEND entry is driven to memory if !stall_in_M. The entry becomes ISSUED.
  - At most one issue per cycle.
  - A request that is not issued holds until stall_in_M drops; requests are never reordered.
- Response:
  - ready_in_M marks entry ldstID_in_M DONE. A load captures data_in_M; a store keeps its own data.
  - A response to an entry that is not ISSUED is ignored.
- Retire:
  - If the head entry is DONE, register its fields onto the _C outputs, pulse ready_out_C, set the entry FREE, and increment head.
  - At most one retire per cycle.
- Same-cycle events:
  - Allocation, issue, response and retire may all occur in one cycle.
  - count' = count + alloc - retire.
  - full and stall_out_C are derived from the registered count, so a retire does not free a slot for a same-cycle allocation.
- Reset:
  - All entries FREE; head = tail = 0; count = 0; empty = 1; all other outputs 0.
  - Reset mid-operation discards all entries. Responses arriving after reset are ignored because no entry is ISSUED.

## Timing
- Outputs:
  - All _M and _C outputs are registered.
  - full, empty, count and stall_out_C are combinational from registered state.
  - stall_out_C = full.
- Memory path:
  - An entry allocated at edge N is issued no earlier than edge N+1, so valid_out_M is first visible after edge N+1.
  - valid_out_M is high for exactly one cycle per issued request.
- Forwarded load: allocated at edge N, DONE after edge N, retired at edge N+1 at the earliest.
- Response at edge R on the head entry gives retire at edge R+1.
- Wrap-around: pointers are ID_W bits and wrap naturally; count is ID_W+1 bits so full and empty are distinct.

## Structure
- Shared package `ldst_pkg`:
  - entry state enum (FREE/PEND/ISSUED/DONE)
  - the entry struct
  - ID_W derivation helper
- One sub-module, `ldst_fwd_match`: combinational age-ordered CAM taking head, new index, per-entry valid/rw/addr and the lookup address. Outputs hit and the youngest older matching index.

## Test plan
- Store addr 0x10 data 0xAA, then a load addr 0x10 the next cycle:
  - the load never appears on valid_out_M
  - both retire in order
  - the load retires with data_out_C = 0xAA
- 16 back-to-back loads to distinct addresses with the 2-cycle cache:
  - full asserts after the 16th
  - a 17th allocation is dropped
  - IDs 0..15 retire in order
  - tail wraps to 0
- Out-of-order responses, ID 2 then ID 0 then ID 1:
  - ready_out_C pulses for 0, 1, 2 in order
  - ID 2 is held until 0 and 1 are DONE
- stall_in_M held high for 5 cycles with 3 PEND entries:
  - no valid_out_M during the stall
  - then issues on 3 consecutive cycles in age order
- Reset asserted with 4 ISSUED entries, followed by a late ready_in_M for ID 1:
  - count = 0, empty = 1
  - ready_out_C stays 0
- Two stores to 0x20 (0x11 then 0x22), then a load of 0x20: the load forwards 0x22 (youngest store).
